// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sdram_port_arbiter
// Purpose  : Merges the per-port ca/dm streams onto one controller interface.
//            Grants are round-robin and last a bounded run of beats. Define
//            SDRAM_ARB_FIXED_PRIO_EN to pick the lowest-index port instead.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_port_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int ADR_WIDTH = 32,
    parameter int DQ_WIDTH  = 16,
    parameter int MAX_BEATS = 16
) (
    input  logic                              sdram_clk,
    input  logic                              sdram_rst,
    input  logic [NUM_PORTS*ADR_WIDTH-1:0]    p_ca_adr_i,
    input  logic [NUM_PORTS-1:0]              p_ca_we_i,
    input  logic [NUM_PORTS-1:0]              p_ca_valid_i,
    output logic [NUM_PORTS-1:0]              p_ca_ready_o,
    input  logic [NUM_PORTS*DQ_WIDTH-1:0]     p_dm_dat_i,
    input  logic [NUM_PORTS*DQ_WIDTH/8-1:0]   p_dm_sel_i,
    input  logic [NUM_PORTS-1:0]              p_dm_valid_i,
    output logic [ADR_WIDTH-1:0]              ca_adr_o,
    output logic                              ca_we_o,
    output logic                              ca_valid_o,
    input  logic                              ca_ready_i,
    output logic [DQ_WIDTH-1:0]               dm_dat_o,
    output logic [DQ_WIDTH/8-1:0]             dm_sel_o,
    output logic                              dm_valid_o,
    output logic [NUM_PORTS-1:0]              gnt_o
);

    localparam int SEL_WIDTH = DQ_WIDTH / 8;
    localparam int IDX_W     = $clog2(NUM_PORTS);
    localparam int CNT_W     = $clog2(MAX_BEATS) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BEATS - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t                 state, state_nxt;
    logic [NUM_PORTS-1:0]   gnt, gnt_nxt;
    logic [IDX_W-1:0]       gnt_idx, gnt_idx_nxt;
    logic [CNT_W-1:0]       beat_cnt, beat_cnt_nxt;
    logic                   found;
    logic [IDX_W-1:0]       pick_idx;
    logic                   beat;

    logic [ADR_WIDTH-1:0]   adr_arr [NUM_PORTS];
    logic [DQ_WIDTH-1:0]    dat_arr [NUM_PORTS];
    logic [SEL_WIDTH-1:0]   sel_arr [NUM_PORTS];

    for (genvar n = 0; n < NUM_PORTS; n++) begin : g_unpack
        assign adr_arr[n] = p_ca_adr_i[n*ADR_WIDTH +: ADR_WIDTH];
        assign dat_arr[n] = p_dm_dat_i[n*DQ_WIDTH +: DQ_WIDTH];
        assign sel_arr[n] = p_dm_sel_i[n*SEL_WIDTH +: SEL_WIDTH];
    end

`ifdef SDRAM_ARB_FIXED_PRIO_EN
    always_comb begin
        found    = 1'b0;
        pick_idx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!found && p_ca_valid_i[i]) begin
                found    = 1'b1;
                pick_idx = IDX_W'(i);
            end
        end
    end
`else
    logic [IDX_W-1:0] last_gnt;

    // Two passes: ports above the last winner first, then wrap to the rest.
    always_comb begin
        found    = 1'b0;
        pick_idx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!found && p_ca_valid_i[i] && (i > int'(last_gnt))) begin
                found    = 1'b1;
                pick_idx = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!found && p_ca_valid_i[i] && (i <= int'(last_gnt))) begin
                found    = 1'b1;
                pick_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge sdram_clk) begin
        if (sdram_rst) begin
            last_gnt <= IDX_W'(NUM_PORTS - 1);
        end else if (state == IDLE && found) begin
            last_gnt <= pick_idx;
        end
    end
`endif

    always_ff @(posedge sdram_clk) begin
        if (sdram_rst) begin
            state    <= IDLE;
            gnt      <= '0;
            gnt_idx  <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            gnt      <= gnt_nxt;
            gnt_idx  <= gnt_idx_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

    assign beat = ca_valid_o & ca_ready_i;

    always_comb begin
        state_nxt    = state;
        gnt_nxt      = gnt;
        gnt_idx_nxt  = gnt_idx;
        beat_cnt_nxt = beat_cnt;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt    = GRANT;
                    gnt_idx_nxt  = pick_idx;
                    gnt_nxt      = {{(NUM_PORTS-1){1'b0}}, 1'b1} << pick_idx;
                    beat_cnt_nxt = '0;
                end
            end
            GRANT: begin
                if (beat) begin
                    beat_cnt_nxt = beat_cnt + CNT_W'(1);
                end
                if (!p_ca_valid_i[gnt_idx] || (beat && beat_cnt == LAST_BEAT)) begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
            end
        endcase
    end

    // Output mux is driven only while granted so IDLE presents all zeros.
    always_comb begin
        ca_adr_o   = '0;
        ca_we_o    = 1'b0;
        ca_valid_o = 1'b0;
        dm_dat_o   = '0;
        dm_sel_o   = '0;
        dm_valid_o = 1'b0;
        if (state == GRANT) begin
            ca_adr_o   = adr_arr[gnt_idx];
            ca_we_o    = p_ca_we_i[gnt_idx];
            ca_valid_o = p_ca_valid_i[gnt_idx];
            dm_dat_o   = dat_arr[gnt_idx];
            dm_sel_o   = sel_arr[gnt_idx];
            dm_valid_o = p_dm_valid_i[gnt_idx];
        end
    end

    assign p_ca_ready_o = gnt & {NUM_PORTS{ca_ready_i}};
    assign gnt_o        = gnt;

endmodule
`default_nettype wire

// File: tb/tb_sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_port_arbiter
// Purpose  : Vector table with scoreboard plus hand sequences for the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_port_arbiter;

    localparam int NP = 2;
    localparam int AW = 32;
    localparam int DW = 16;
    localparam int MB = 4;
    localparam int NV = 25;

`ifdef SDRAM_ARB_FIXED_PRIO_EN
    localparam logic [1:0] ALT = 2'b01;
`else
    localparam logic [1:0] ALT = 2'b10;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [NP*AW-1:0]  p_ca_adr;
    logic [NP-1:0]     p_ca_we;
    logic [NP-1:0]     p_ca_valid;
    logic [NP-1:0]     p_ca_ready;
    logic [NP*DW-1:0]  p_dm_dat;
    logic [NP*DW/8-1:0] p_dm_sel;
    logic [NP-1:0]     p_dm_valid;
    logic [AW-1:0]     ca_adr;
    logic              ca_we;
    logic              ca_valid;
    logic              ca_ready;
    logic [DW-1:0]     dm_dat;
    logic [DW/8-1:0]   dm_sel;
    logic              dm_valid;
    logic [NP-1:0]     gnt;

    sdram_port_arbiter #(
        .NUM_PORTS (NP),
        .ADR_WIDTH (AW),
        .DQ_WIDTH  (DW),
        .MAX_BEATS (MB)
    ) dut (
        .sdram_clk    (clk),
        .sdram_rst    (rst),
        .p_ca_adr_i   (p_ca_adr),
        .p_ca_we_i    (p_ca_we),
        .p_ca_valid_i (p_ca_valid),
        .p_ca_ready_o (p_ca_ready),
        .p_dm_dat_i   (p_dm_dat),
        .p_dm_sel_i   (p_dm_sel),
        .p_dm_valid_i (p_dm_valid),
        .ca_adr_o     (ca_adr),
        .ca_we_o      (ca_we),
        .ca_valid_o   (ca_valid),
        .ca_ready_i   (ca_ready),
        .dm_dat_o     (dm_dat),
        .dm_sel_o     (dm_sel),
        .dm_valid_o   (dm_valid),
        .gnt_o        (gnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [1:0] valid;
        logic       ready;
        logic       chk;
        logic [1:0] gnt;
        logic       cav;
        logic [1:0] rdy;
    } vec_t;

    typedef struct {
        int         k;
        logic [1:0] gnt;
        logic       cav;
        logic [1:0] rdy;
    } exp_t;

    vec_t vecs [NV];
    exp_t sbq [$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(logic r, logic [1:0] v, logic rd, logic c,
                                logic [1:0] g, logic cv, logic [1:0] ry);
        vec_t t;
        t.rst = r; t.valid = v; t.ready = rd; t.chk = c;
        t.gnt = g; t.cav = cv; t.rdy = ry;
        return t;
    endfunction

    function automatic logic [AW-1:0] adr_of(int p, int k);
        return 32'h1000_0000 | (32'(k) << 8) | 32'(p);
    endfunction

    function automatic logic [DW-1:0] dat_of(int p, int k);
        return 16'(32'hA000 + k * 16 + p);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_tbl(int k, logic [1:0] v, logic rd);
        p_ca_adr   = {adr_of(1, k), adr_of(0, k)};
        p_dm_dat   = {dat_of(1, k), dat_of(0, k)};
        p_ca_valid = v;
        p_dm_valid = v;
        ca_ready   = rd;
    endtask

    initial begin
        exp_t e;
        int   p;

        rst        = 1'b1;
        p_ca_we    = 2'b10;
        p_dm_sel   = {2'b10, 2'b01};
        p_ca_adr   = '0;
        p_dm_dat   = '0;
        p_ca_valid = '0;
        p_dm_valid = '0;
        ca_ready   = 1'b0;

        vecs[0] = mk(1'b1, 2'b11, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00);
        vecs[1] = mk(1'b1, 2'b11, 1'b1, 1'b1, 2'b00, 1'b0, 2'b00);
        vecs[2] = mk(1'b0, 2'b11, 1'b1, 1'b1, 2'b00, 1'b0, 2'b00);
        for (int k = 3; k <= 6; k++)   vecs[k] = mk(1'b0, 2'b11, 1'b1, 1'b1, 2'b01, 1'b1, 2'b01);
        vecs[7] = mk(1'b0, 2'b11, 1'b1, 1'b1, 2'b00, 1'b0, 2'b00);
        for (int k = 8; k <= 11; k++)  vecs[k] = mk(1'b0, 2'b11, 1'b1, 1'b1, ALT, 1'b1, ALT);
        vecs[12] = mk(1'b0, 2'b11, 1'b1, 1'b1, 2'b00, 1'b0, 2'b00);
        for (int k = 13; k <= 16; k++) vecs[k] = mk(1'b0, 2'b11, 1'b1, 1'b1, 2'b01, 1'b1, 2'b01);
        vecs[17] = mk(1'b0, 2'b11, 1'b1, 1'b1, 2'b00, 1'b0, 2'b00);
        vecs[18] = mk(1'b0, 2'b11, 1'b1, 1'b1, ALT, 1'b1, ALT);
        // Reset lands while the second beat of this grant is on the bus.
        vecs[19] = mk(1'b1, 2'b11, 1'b1, 1'b1, ALT, 1'b1, ALT);
        vecs[20] = mk(1'b0, 2'b11, 1'b1, 1'b1, 2'b00, 1'b0, 2'b00);
        vecs[21] = mk(1'b0, 2'b11, 1'b1, 1'b1, 2'b01, 1'b1, 2'b01);
        vecs[22] = mk(1'b0, 2'b00, 1'b1, 1'b1, 2'b01, 1'b0, 2'b01);
        vecs[23] = mk(1'b0, 2'b10, 1'b1, 1'b1, 2'b00, 1'b0, 2'b00);
        vecs[24] = mk(1'b0, 2'b10, 1'b1, 1'b1, 2'b10, 1'b1, 2'b10);

        for (int k = 0; k < NV; k++) begin
            tick();
            rst = vecs[k].rst;
            drive_tbl(k, vecs[k].valid, vecs[k].ready);
            if (vecs[k].chk) begin
                e.k = k; e.gnt = vecs[k].gnt; e.cav = vecs[k].cav; e.rdy = vecs[k].rdy;
                sbq.push_back(e);
            end
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                p = (e.gnt == 2'b10) ? 1 : 0;
                check($sformatf("gnt[%0d]", e.k), 64'(gnt), 64'(e.gnt));
                check($sformatf("ca_valid[%0d]", e.k), 64'(ca_valid), 64'(e.cav));
                check($sformatf("dm_valid[%0d]", e.k), 64'(dm_valid), 64'(e.cav));
                check($sformatf("p_ready[%0d]", e.k), 64'(p_ca_ready), 64'(e.rdy));
                if (e.gnt != 2'b00) begin
                    check($sformatf("adr[%0d]", e.k), 64'(ca_adr), 64'(adr_of(p, e.k)));
                    check($sformatf("dat[%0d]", e.k), 64'(dm_dat), 64'(dat_of(p, e.k)));
                    check($sformatf("we[%0d]", e.k), 64'(ca_we), 64'(p == 1));
                    check($sformatf("sel[%0d]", e.k), 64'(dm_sel), (p == 1) ? 64'h2 : 64'h1);
                end else begin
                    check($sformatf("adr0[%0d]", e.k), 64'(ca_adr), 64'h0);
                    check($sformatf("dat0[%0d]", e.k), 64'(dm_dat), 64'h0);
                end
            end
        end

        // Early release: port 1 alone for three beats, then valid drops.
        tick();
        rst = 1'b1; p_ca_valid = 2'b00; p_dm_valid = 2'b00; ca_ready = 1'b1;
        tick();
        rst = 1'b0; p_ca_valid = 2'b10; p_dm_valid = 2'b10;
        p_ca_adr[AW +: AW] = 32'h100;
        @(negedge clk);
        check("er_idle_gnt", 64'(gnt), 64'h0);
        tick();
        @(negedge clk);
        check("er_gnt", 64'(gnt), 64'h2);
        check("er_adr0", 64'(ca_adr), 64'h100);
        tick();
        p_ca_adr[AW +: AW] = 32'h102;
        @(negedge clk);
        check("er_adr1", 64'(ca_adr), 64'h102);
        tick();
        p_ca_adr[AW +: AW] = 32'h104;
        @(negedge clk);
        check("er_adr2", 64'(ca_adr), 64'h104);
        check("er_cav2", 64'(ca_valid), 64'h1);
        tick();
        p_ca_valid = 2'b00; p_dm_valid = 2'b00;
        @(negedge clk);
        check("er_drop_cav", 64'(ca_valid), 64'h0);
        check("er_drop_gnt", 64'(gnt), 64'h2);
        tick();
        @(negedge clk);
        check("er_released", 64'(gnt), 64'h0);
        check("er_beat_cnt", 64'(dut.beat_cnt), 64'h3);

        // Backpressure: port 0 granted with ready low for ten cycles.
        tick();
        p_ca_valid = 2'b01; p_dm_valid = 2'b01; ca_ready = 1'b0;
        p_ca_adr[0 +: AW] = 32'hABC0;
        p_dm_dat[0 +: DW] = 16'h5A5A;
        @(negedge clk);
        check("bp_idle_gnt", 64'(gnt), 64'h0);
        for (int c = 0; c < 10; c++) begin
            tick();
            @(negedge clk);
            check($sformatf("bp_gnt[%0d]", c), 64'(gnt), 64'h1);
            check($sformatf("bp_cav[%0d]", c), 64'(ca_valid), 64'h1);
            check($sformatf("bp_adr[%0d]", c), 64'(ca_adr), 64'hABC0);
            check($sformatf("bp_dat[%0d]", c), 64'(dm_dat), 64'h5A5A);
            check($sformatf("bp_rdy[%0d]", c), 64'(p_ca_ready), 64'h0);
        end
        tick();
        ca_ready = 1'b1;
        @(negedge clk);
        check("bp_rdy_up", 64'(p_ca_ready), 64'h1);
        // Valid drops as ready stays high: no beat, grant releases.
        tick();
        p_ca_valid = 2'b00; p_dm_valid = 2'b00;
        @(negedge clk);
        check("bp_beat_done", 64'(dut.beat_cnt), 64'h1);
        check("bp_hold_gnt", 64'(gnt), 64'h1);
        tick();
        @(negedge clk);
        check("bp_released", 64'(gnt), 64'h0);
        check("bp_no_beat", 64'(dut.beat_cnt), 64'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Sits directly downstream of the Wishbone port stage, in the sdram_clk domain.
- Merges the command/address (ca_*) and write-data (dm_*) streams of NUM_PORTS port stages onto the single controller-facing interface.
- Arbitration is round-robin; a grant is held for a run of consecutive beats.
- Controller read data (r_*) is broadcast to the ports outside this block and does not pass through it.

Parameters:
- NUM_PORTS, 2, number of upstream port stages; legal range 2..8.
- ADR_WIDTH, 32, ca address width.
- DQ_WIDTH, 16, dm data width; dm sel width is DQ_WIDTH/8.
- MAX_BEATS, 16, maximum handshaked beats per grant before a forced release; legal range 1..256.

Ports:
- sdram_clk  in  1  clock.
- sdram_rst  in  1  synchronous reset, active-high.
- p_ca_adr_i  in  NUM_PORTS*ADR_WIDTH  packed per-port address; port n occupies bits [n*ADR_WIDTH +: ADR_WIDTH].
- p_ca_we_i  in  NUM_PORTS  per-port write-enable.
- p_ca_valid_i  in  NUM_PORTS  per-port command valid.
- p_ca_ready_o  out  NUM_PORTS  per-port ready; also acts as the per-port dm ready.
- p_dm_dat_i  in  NUM_PORTS*DQ_WIDTH  packed per-port write data.
- p_dm_sel_i  in  NUM_PORTS*DQ_WIDTH/8  packed per-port byte selects.
- p_dm_valid_i  in  NUM_PORTS  per-port write-data valid.
- ca_adr_o  out  ADR_WIDTH  muxed address to controller.
- ca_we_o  out  1  muxed write-enable.
- ca_valid_o  out  1  muxed command valid.
- ca_ready_i  in  1  controller ready; shared by ca and dm.
- dm_dat_o  out  DQ_WIDTH  muxed write data.
- dm_sel_o  out  DQ_WIDTH/8  muxed byte selects.
- dm_valid_o  out  1  muxed data valid.
- gnt_o  out  NUM_PORTS  one-hot current grant; 0 when idle.

Behaviour:
- State machine with two states, IDLE and GRANT. All state is registered; output muxing is combinational from the registered grant.
- Reset (sdram_rst sampled high at a sdram_clk edge):
  - state=IDLE, gnt=0, last_gnt=NUM_PORTS-1, beat_cnt=0.
  - All outputs 0: ca_valid_o, dm_valid_o, p_ca_ready_o, gnt_o, ca_adr_o, ca_we_o, dm_dat_o, dm_sel_o.
  - Reset asserted mid-grant drops the grant on the next edge; no partial beat is completed afterwards.
- IDLE:
  - All outputs 0.
  - If any p_ca_valid_i is set, pick the first valid port searching upward (with wrap) from last_gnt+1. Load gnt, set last_gnt to that port, clear beat_cnt, go to GRANT.
  - Arbitration latency: request in cycle N gives ca_valid_o in cycle N+1 at the earliest.
- GRANT (granted port g):
  - ca_adr_o/ca_we_o/ca_valid_o and dm_dat_o/dm_sel_o/dm_valid_o are port g's inputs.
  - p_ca_ready_o[g]=ca_ready_i; all other p_ca_ready_o bits are 0.
  - A beat is a cycle with ca_valid_o & ca_ready_i; each beat increments beat_cnt.
  - Release to IDLE at the next edge when either:
    - p_ca_valid_i[g]=0, or
    - a beat occurs with beat_cnt==MAX_BEATS-1.
  - Release produces one idle bubble cycle before the next grant.
  - If valid drops and ready rises in the same cycle, no beat occurs and the block releases.
- A ready-low controller stalls the grant indefinitely; there is no timeout. beat_cnt counts handshakes only.
- Non-granted ports see ready=0 and must hold their inputs stable per the valid/ready rule.
- beat_cnt width is clog2(MAX_BEATS)+1; it never wraps because release occurs at MAX_BEATS.

Optional Feature:
- Macro SDRAM_ARB_FIXED_PRIO_EN.
- Defined: the IDLE pick is the lowest-index valid port (port 0 highest priority); last_gnt is unused. MAX_BEATS release still applies, so lower ports can starve only when higher ones re-request immediately.
- Undefined: round-robin as described in Behaviour.

Test Plan:
- Reset then idle: sdram_rst=1 for 2 cycles with all p_ca_valid_i=1 -> all outputs 0 during reset. After release, gnt_o=2'b01 one cycle later and ca_valid_o=1 with port 0's address.
- Round-robin: both ports hold valid, ca_ready_i=1, MAX_BEATS=4 -> 4 beats from port 0, 1 bubble, 4 beats from port 1, 1 bubble, then port 0. p_ca_ready_o is never 2'b11.
- Early release: port 1 alone, valid for 3 beats with adr 0x100,0x102,0x104 then drops -> ca_adr_o follows that sequence; IDLE the cycle after valid drops; beat_cnt ends at 3.
- Backpressure: port 0 granted, ca_ready_i=0 for 10 cycles -> ca_valid_o=1 held, ca_adr_o/dm_dat_o stable, p_ca_ready_o=0, no release. Raising ready completes a beat.
- Reset mid-grant: port 1 granted at beat 2, sdram_rst pulsed for 1 cycle -> next cycle gnt_o=0 and ca_valid_o=0. First grant after reset goes to port 0.
- With SDRAM_ARB_FIXED_PRIO_EN, both valid, MAX_BEATS=2 -> grant sequence 0,0,0,...; port 1 is granted only after port 0 drops valid.
